// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle fwd/add/and/or, iterative shift-add multiply and bit-serial shifter.
// Optional build macro MULTICYCLE_ALU_EARLY_TERM_EN ends a multiply once the remaining multiplier bits are zero.
module multicycle_alu #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHAMT_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic [2:0]            ALUOP,
    input  logic                  SUB,
    input  logic [DATA_WIDTH-1:0] DATA1,
    input  logic [DATA_WIDTH-1:0] DATA2,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic [DATA_WIDTH-1:0] RESULT_HI,
    output logic                  ZERO,
    output logic [1:0]            dbg_state
);

    localparam int W       = DATA_WIDTH;
    localparam int MAX_SH  = (1 << SHAMT_WIDTH) - 1;
    localparam int CNT_MAX = (MAX_SH > W) ? MAX_SH : W;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Handshake: START is taken on any rising edge where the FSM is not in EXEC;
    // DONE pulses for one cycle with RESULT/RESULT_HI/ZERO valid and held afterwards.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            mul_q, mul_d;
    logic [1:0]      mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    hi_q, hi_d;
    logic            zero_q, zero_d;

    logic            accept;
    logic [W-1:0]    addend;
    logic [W-1:0]    simple_res;
    logic [2*W-1:0]  mul_sum;
    logic [W-1:0]    mplier_nx;
    logic [W-1:0]    sh_cur;
    logic [W-1:0]    sh_next;
    logic            last_mul;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            mul_q    <= 1'b0;
            mode_q   <= 2'b00;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            res_q    <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mul_q    <= mul_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mul_d      = mul_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        res_d      = res_q;
        hi_d       = hi_q;
        zero_d     = zero_q;

        accept     = START && (state_q != S_EXEC);
        addend     = SUB ? (~DATA2 + W'(1)) : DATA2;
        mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_nx  = mplier_q >> 1;
        sh_cur     = acc_q[W-1:0];

        case (mode_q)
            2'b00:   sh_next = {sh_cur[W-2:0], 1'b0};
            2'b01:   sh_next = {1'b0, sh_cur[W-1:1]};
            2'b10:   sh_next = {sh_cur[W-1], sh_cur[W-1:1]};
            default: sh_next = {sh_cur[0], sh_cur[W-1:1]};
        endcase

`ifdef MULTICYCLE_ALU_EARLY_TERM_EN
        last_mul = (cnt_q == CW'(1)) || (mplier_nx == '0);
`else
        last_mul = (cnt_q == CW'(1));
`endif

        case (ALUOP)
            3'b000:  simple_res = DATA2;
            3'b001:  simple_res = DATA1 + addend;
            3'b010:  simple_res = DATA1 & DATA2;
            3'b011:  simple_res = DATA1 | DATA2;
            default: simple_res = '0;
        endcase

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    mul_d  = (ALUOP == 3'b100);
                    mode_d = DATA2[SHAMT_WIDTH+1:SHAMT_WIDTH];
                    if (ALUOP == 3'b100) begin
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, DATA1};
                        mplier_d = DATA2;
                        cnt_d    = CW'(W);
                        state_d  = S_EXEC;
`ifdef MULTICYCLE_ALU_EARLY_TERM_EN
                        if (DATA2 == '0) begin
                            state_d = S_DONE;
                            res_d   = '0;
                            hi_d    = '0;
                            zero_d  = 1'b1;
                        end
`endif
                    end else if (ALUOP == 3'b101) begin
                        acc_d = {{W{1'b0}}, DATA1};
                        cnt_d = CW'(DATA2[SHAMT_WIDTH-1:0]);
                        if (DATA2[SHAMT_WIDTH-1:0] == '0) begin
                            state_d = S_DONE;
                            res_d   = DATA1;
                            hi_d    = '0;
                            zero_d  = (DATA1 == '0);
                        end else begin
                            state_d = S_EXEC;
                        end
                    end else begin
                        state_d = S_DONE;
                        res_d   = simple_res;
                        hi_d    = '0;
                        zero_d  = (simple_res == '0);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - CW'(1);
                if (mul_q) begin
                    // Multiplicand walks left while the multiplier drains right, one bit per cycle.
                    acc_d    = mul_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_nx;
                    if (last_mul) begin
                        state_d = S_DONE;
                        res_d   = mul_sum[W-1:0];
                        hi_d    = mul_sum[2*W-1:W];
                        zero_d  = (mul_sum[W-1:0] == '0);
                    end
                end else begin
                    acc_d = {{W{1'b0}}, sh_next};
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                        res_d   = sh_next;
                        hi_d    = '0;
                        zero_d  = (sh_next == '0);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY      = (state_q == S_EXEC);
    assign DONE      = (state_q == S_DONE);
    assign RESULT    = res_q;
    assign RESULT_HI = hi_q;
    assign ZERO      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: driver pushes model results, a monitor pops them on DONE.
module tb_multicycle_alu;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   aluop;
    logic         sub;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic [1:0]   dbg_state;

    logic [2*W:0] exp_q[$];
    int           cyc_q[$];
    int           cyc;
    int           checks;
    int           errors;

    multicycle_alu #(.DATA_WIDTH(W), .SHAMT_WIDTH(4)) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .START(start),
        .ALUOP(aluop),
        .SUB(sub),
        .DATA1(data1),
        .DATA2(data2),
        .BUSY(busy),
        .DONE(done),
        .RESULT(result),
        .RESULT_HI(result_hi),
        .ZERO(zero),
        .dbg_state(dbg_state)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: plain arithmetic on the operation definitions
    function automatic void model(input logic [2:0] op, input logic sb, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] res,
                                  output logic [W-1:0] hi, output int lat);
        logic [2*W-1:0]     p;
        logic signed [W-1:0] sa;
        int                 n;
        int                 r;
        logic [1:0]         mode;
        hi  = '0;
        res = '0;
        lat = 1;
        case (op)
            3'd0: res = b;
            3'd1: res = sb ? (a - b) : (a + b);
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: begin
                p   = (2*W)'(a) * (2*W)'(b);
                res = p[W-1:0];
                hi  = p[2*W-1:W];
                lat = W + 1;
`ifdef MULTICYCLE_ALU_EARLY_TERM_EN
                lat = 1;
                for (int i = 0; i < W; i++) if (b[i]) lat = i + 2;
`endif
            end
            3'd5: begin
                n    = int'(b[3:0]);
                mode = b[5:4];
                lat  = n + 1;
                sa   = a;
                case (mode)
                    2'd0: res = (n >= W) ? '0 : (a << n);
                    2'd1: res = (n >= W) ? '0 : (a >> n);
                    2'd2: res = (n >= W) ? {W{a[W-1]}} : W'(sa >>> n);
                    default: begin
                        r   = n % W;
                        res = (r == 0) ? a : ((a >> r) | (a << (W - r)));
                    end
                endcase
            end
            default: res = '0;
        endcase
    endfunction

    // driver
    task automatic issue(input logic [2:0] op, input logic sb, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic use_tab,
                         input logic [W-1:0] t_res, input logic [W-1:0] t_hi);
        logic [W-1:0] r;
        logic [W-1:0] h;
        int           lat;
        int           n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", busy, n);
        end
        model(op, sb, a, b, r, h, lat);
        if (use_tab) begin
            r = t_res;
            h = t_hi;
        end
        aluop = op;
        sub   = sb;
        data1 = a;
        data2 = b;
        start = 1'b1;
        @(negedge clk);
        exp_q.push_back({h, r, (r == '0)});
        cyc_q.push_back(cyc + lat - 1);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({busy, done, result, result_hi, zero} != '0 || dbg_state != 2'd0) begin
            errors++;
            $display("FAIL %s: busy=%0b done=%0b result=%02h hi=%02h zero=%0b state=%0d, required all 0",
                     tag, busy, done, result, result_hi, zero, dbg_state);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [2*W:0] e;
        int           ec;
        #1;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending op", cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                checks++;
                if ({result_hi, result, zero} !== e) begin
                    errors++;
                    $display("FAIL result: hi=%02h res=%02h zero=%0b, required hi=%02h res=%02h zero=%0b",
                             result_hi, result, zero, e[2*W:W+1], e[W:1], e[0]);
                end
                checks++;
                if (cyc != ec) begin
                    errors++;
                    $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, ec);
                end
            end
        end
    end

    // stimulus
    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        aluop  = '0;
        sub    = 1'b0;
        data1  = '0;
        data2  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;

        // directed vectors
        issue(3'd1, 1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 8'h00);
        issue(3'd1, 1'b0, 8'hFF, 8'h02, 1'b1, 8'h01, 8'h00);
        issue(3'd4, 1'b0, 8'd13, 8'd11, 1'b1, 8'h8F, 8'h00);
        issue(3'd4, 1'b0, 8'd200, 8'd200, 1'b1, 8'h40, 8'h9C);
        issue(3'd5, 1'b0, 8'h90, 8'h23, 1'b1, 8'hF2, 8'h00);
        issue(3'd5, 1'b0, 8'h81, 8'h31, 1'b1, 8'hC0, 8'h00);
        issue(3'd5, 1'b0, 8'hFF, 8'h1F, 1'b1, 8'h00, 8'h00);
        issue(3'd5, 1'b0, 8'hA5, 8'h30, 1'b1, 8'hA5, 8'h00);
        issue(3'd4, 1'b0, 8'd7, 8'd0, 1'b1, 8'h00, 8'h00);
        issue(3'd4, 1'b0, 8'd7, 8'd3, 1'b1, 8'h15, 8'h00);
        issue(3'd6, 1'b1, 8'h3C, 8'h11, 1'b1, 8'h00, 8'h00);
        issue(3'd0, 1'b0, 8'h3C, 8'h5A, 1'b1, 8'h5A, 8'h00);
        repeat (2) @(negedge clk);

        // START with new operands while a multiply is iterating is ignored
        issue(3'd4, 1'b0, 8'd200, 8'd200, 1'b1, 8'h40, 8'h9C);
        @(negedge clk);
        aluop = 3'd1;
        data1 = 8'h01;
        data2 = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data1 = 8'h77;

        // reset three cycles into a multiply abandons it
        issue(3'd4, 1'b0, 8'd255, 8'd255, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        aluop = 3'd1;
        start = 1'b1;
        #1;
        check_reset_outputs("reset_mid_mul");
        exp_q.delete();
        cyc_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (14) @(negedge clk);
        check_reset_outputs("after_abandon");

        // first START right after reset release is accepted on the next edge
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd1, 1'b0, 8'h10, 8'h20, 1'b1, 8'h30, 8'h00);

        // randomized traffic, mostly back-to-back
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 8'h00, 8'h00);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d ops pending, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
